// File: rtl/sdram_port_arbiter_pkg.sv
// Shared SDRAM controller definitions: command encoding, arbiter states and
// the grant-index width helper.
package sdram_pkg;
  localparam int CMD_W = 5;
  localparam logic [CMD_W-1:0] CMD_NOP = 5'b10111;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_AREF,
    ST_XFER
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Burst-engine side of the SDRAM arbiter: per-port requests, packed command/
// address/data buses, and the returned enable/grant.
interface sdram_port_arbiter_if import sdram_pkg::*; #(
  parameter int NPORT  = 2,
  parameter int ADDR_W = 12,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16,
  parameter int GNT_W  = idx_w(NPORT)
) ();
  logic [NPORT-1:0]        port_req;
  logic [NPORT-1:0]        port_wr;
  logic [NPORT-1:0]        port_ack;
  logic [NPORT*CMD_W-1:0]  port_cmd;
  logic [NPORT*ADDR_W-1:0] port_addr;
  logic [NPORT*BA_W-1:0]   port_bank;
  logic [NPORT*DQ_W-1:0]   port_wdata;
  logic [NPORT-1:0]        port_en;
  logic [GNT_W-1:0]        grant_id;

  modport master (
    output port_req, port_wr, port_ack, port_cmd, port_addr, port_bank, port_wdata,
    input  port_en, grant_id
  );

  modport slave (
    input  port_req, port_wr, port_ack, port_cmd, port_addr, port_bank, port_wdata,
    output port_en, grant_id
  );
endinterface

// File: rtl/sdram_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting port at or after i_ptr,
// wrapping modulo NPORT.
module rr_picker #(
  parameter int NPORT = 2,
  parameter int GNT_W = 1
) (
  input  logic [NPORT-1:0] i_req,
  input  logic [GNT_W-1:0] i_ptr,
  output logic [GNT_W-1:0] o_idx,
  output logic             o_vld
);
  always_comb begin
    int k;
    k     = 0;
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      k = int'(i_ptr) + i;
      if (k >= NPORT) k = k - NPORT;
      if (!o_vld && i_req[k]) begin
        o_vld = 1'b1;
        o_idx = GNT_W'(k);
      end
    end
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// SDRAM pin arbiter: init engine, refresh engine and NPORT burst engines share
// the command/address/DQ pins under a four-state FSM with round-robin ports.
module sdram_port_arbiter import sdram_pkg::*; #(
  parameter int NPORT  = 2,
  parameter int ADDR_W = 12,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
) (
  input  logic              S_CLK,
  input  logic              RST_N,
  input  logic              init_done,
  input  logic [CMD_W-1:0]  init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_ack,
  input  logic [CMD_W-1:0]  aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  output logic              aref_en,
  sdram_port_arbiter_if.slave bus,
  output logic [CMD_W-1:0]  sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_bank,
  output logic [DQ_W-1:0]   dq_out,
  output logic              dq_oe
);
  localparam int GNT_W = idx_w(NPORT);

  state_t           r_state;
  logic [GNT_W-1:0] r_grant;
  logic [GNT_W-1:0] r_last;
  logic [NPORT-1:0] r_port_en;
  logic             r_aref_en;

  logic [GNT_W-1:0] w_start;
  logic [GNT_W-1:0] w_win;
  logic             w_win_vld;
  logic             w_ack;

  assign w_start = (r_last == GNT_W'(NPORT - 1)) ? '0 : r_last + 1'b1;
  assign w_ack   = bus.port_ack[r_grant];

  rr_picker #(.NPORT(NPORT), .GNT_W(GNT_W)) u_rr_picker (
    .i_req (bus.port_req),
    .i_ptr (w_start),
    .o_idx (w_win),
    .o_vld (w_win_vld)
  );

  // Refresh waits for the current burst to finish; it never pre-empts one.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_INIT;
      r_grant   <= '0;
      r_last    <= GNT_W'(NPORT - 1);
      r_port_en <= '0;
      r_aref_en <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: if (init_done) r_state <= ST_IDLE;
        ST_IDLE: begin
          if (aref_req) begin
            r_state   <= ST_AREF;
            r_aref_en <= 1'b1;
          end else if (w_win_vld) begin
            r_state          <= ST_XFER;
            r_grant          <= w_win;
            r_port_en        <= '0;
            r_port_en[w_win] <= 1'b1;
          end
        end
        ST_XFER: begin
          if (w_ack) begin
            r_last    <= r_grant;
            r_port_en <= '0;
            if (aref_req) begin
              r_state   <= ST_AREF;
              r_aref_en <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_AREF: begin
          if (aref_ack) begin
            r_state   <= ST_IDLE;
            r_aref_en <= 1'b0;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign aref_en      = r_aref_en;
  assign bus.port_en  = r_port_en;
  assign bus.grant_id = r_grant;

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    dq_oe      = 1'b0;
    dq_out     = '0;
    case (r_state)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      ST_XFER: begin
        sdram_cmd  = bus.port_cmd[r_grant*CMD_W +: CMD_W];
        sdram_addr = bus.port_addr[r_grant*ADDR_W +: ADDR_W];
        sdram_bank = bus.port_bank[r_grant*BA_W +: BA_W];
        dq_oe      = bus.port_wr[r_grant];
        if (bus.port_wr[r_grant]) dq_out = bus.port_wdata[r_grant*DQ_W +: DQ_W];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter with four ports: round-robin grant scoreboard,
// refresh ordering, pin mux and asynchronous reset mid-burst.
module tb_sdram_port_arbiter;
  import sdram_pkg::*;

  localparam int NPORT  = 4;
  localparam int ADDR_W = 12;
  localparam int BA_W   = 2;
  localparam int DQ_W   = 16;

  logic              S_CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              init_done;
  logic [CMD_W-1:0]  init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic              aref_req;
  logic              aref_ack;
  logic [CMD_W-1:0]  aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              aref_en;
  logic [CMD_W-1:0]  sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BA_W-1:0]   sdram_bank;
  logic [DQ_W-1:0]   dq_out;
  logic              dq_oe;

  logic [CMD_W-1:0]  p_cmd   [NPORT];
  logic [ADDR_W-1:0] p_addr  [NPORT];
  logic [BA_W-1:0]   p_bank  [NPORT];
  logic [DQ_W-1:0]   p_wdata [NPORT];

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];
  int tb_last;
  int gid;

  always #5 S_CLK = ~S_CLK;

  sdram_port_arbiter_if #(.NPORT(NPORT), .ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) bus ();

  sdram_port_arbiter #(.NPORT(NPORT), .ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) dut (
    .S_CLK      (S_CLK),
    .RST_N      (RST_N),
    .init_done  (init_done),
    .init_cmd   (init_cmd),
    .init_addr  (init_addr),
    .aref_req   (aref_req),
    .aref_ack   (aref_ack),
    .aref_cmd   (aref_cmd),
    .aref_addr  (aref_addr),
    .aref_en    (aref_en),
    .bus        (bus),
    .sdram_cmd  (sdram_cmd),
    .sdram_addr (sdram_addr),
    .sdram_bank (sdram_bank),
    .dq_out     (dq_out),
    .dq_oe      (dq_oe)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge S_CLK);
    #1;
  endtask

  function automatic int rr_model(input logic [NPORT-1:0] req, input int last);
    for (int d = 1; d <= NPORT; d++)
      if (req[(last + d) % NPORT]) return (last + d) % NPORT;
    return -1;
  endfunction

  task automatic expect_grant();
    int w;
    w = rr_model(bus.port_req, tb_last);
    if (w >= 0) exp_q.push_back(w);
  endtask

  task automatic wait_grant(output int g);
    int n;
    int e;
    n = 0;
    g = 0;
    while (bus.port_en == '0 && n < 50) begin
      tick();
      n++;
    end
    chk_eq("grant_seen", {63'b0, bus.port_en != '0}, 64'd1);
    chk_eq("sb_nonempty", {63'b0, exp_q.size() != 0}, 64'd1);
    if (bus.port_en == '0 || exp_q.size() == 0) return;
    e = exp_q.pop_front();
    g = e;
    chk_eq("grant_id", bus.grant_id, e);
    chk_eq("port_en_onehot", bus.port_en, 64'd1 << e);
    chk_eq("xfer_cmd", sdram_cmd, p_cmd[e]);
    chk_eq("xfer_addr", sdram_addr, p_addr[e]);
    chk_eq("xfer_bank", sdram_bank, p_bank[e]);
    chk_eq("xfer_dq_oe", dq_oe, bus.port_wr[e]);
    chk_eq("xfer_dq_out", dq_out, bus.port_wr[e] ? p_wdata[e] : '0);
  endtask

  // Grant is visible now; port_ack[g] is sampled on the len-th edge from here.
  task automatic run_burst(input int g, input int len, input bit raise_aref,
                           input logic [NPORT-1:0] next_req);
    for (int c = 1; c < len; c++) begin
      tick();
      if (g == 2 && c == 2) bus.port_ack = 4'b1000;
      if (g == 2 && c == 3) begin
        bus.port_ack = '0;
        chk_eq("foreign_ack_ignored", bus.port_en, 4'b0100);
      end
      if (raise_aref && c == 2) aref_req = 1'b1;
      chk_eq("burst_hold", bus.port_en, 64'd1 << g);
      if (raise_aref) chk_eq("no_preempt", aref_en, 1'b0);
    end
    bus.port_ack[g] = 1'b1;
    bus.port_req    = next_req;
    tick();
    bus.port_ack = '0;
    tb_last      = g;
    chk_eq("burst_end_en", bus.port_en, '0);
  endtask

  initial begin
    init_done  = 1'b0;
    init_cmd   = 5'b01010;
    init_addr  = 12'h400;
    aref_req   = 1'b0;
    aref_ack   = 1'b0;
    aref_cmd   = 5'b10001;
    aref_addr  = 12'h123;
    bus.port_req = '0;
    bus.port_ack = '0;
    bus.port_wr  = 4'b0100;
    for (int k = 0; k < NPORT; k++) begin
      p_cmd[k]   = CMD_W'(k + 8);
      p_addr[k]  = ADDR_W'(12'h100 * (k + 1) + k);
      p_bank[k]  = BA_W'(k);
      p_wdata[k] = DQ_W'(16'h1111 * (k + 1));
    end
    p_wdata[2] = 16'hA5A5;
    for (int k = 0; k < NPORT; k++) begin
      bus.port_cmd[k*CMD_W +: CMD_W]     = p_cmd[k];
      bus.port_addr[k*ADDR_W +: ADDR_W]  = p_addr[k];
      bus.port_bank[k*BA_W +: BA_W]      = p_bank[k];
      bus.port_wdata[k*DQ_W +: DQ_W]     = p_wdata[k];
    end
    tb_last = NPORT - 1;

    #12;
    chk_eq("rst_port_en", bus.port_en, '0);
    chk_eq("rst_aref_en", aref_en, 1'b0);
    chk_eq("rst_grant_id", bus.grant_id, '0);
    chk_eq("rst_dq_oe", dq_oe, 1'b0);
    chk_eq("rst_cmd", sdram_cmd, init_cmd);
    chk_eq("rst_addr", sdram_addr, init_addr);

    @(negedge S_CLK);
    RST_N = 1'b1;
    for (int c = 1; c < 10; c++) tick();
    chk_eq("init_hold_cmd", sdram_cmd, init_cmd);
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    chk_eq("idle_nop_cmd", sdram_cmd, CMD_NOP);
    chk_eq("idle_nop_addr", sdram_addr, '0);

    aref_ack = 1'b1;
    tick();
    aref_ack = 1'b0;
    chk_eq("stray_aref_ack_en", aref_en, 1'b0);
    chk_eq("stray_aref_ack_cmd", sdram_cmd, CMD_NOP);

    bus.port_req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      expect_grant();
      wait_grant(gid);
      run_burst(gid, 8, 1'b0, (r == 4) ? 4'b0000 : 4'b1111);
    end
    tick();
    chk_eq("rr_idle_cmd", sdram_cmd, CMD_NOP);
    chk_eq("rr_idle_en", bus.port_en, '0);

    aref_req     = 1'b1;
    bus.port_req = 4'b0010;
    tick();
    chk_eq("aref_first_en", aref_en, 1'b1);
    chk_eq("aref_first_port_en", bus.port_en, '0);
    chk_eq("aref_cmd", sdram_cmd, aref_cmd);
    chk_eq("aref_addr", sdram_addr, aref_addr);
    chk_eq("aref_dq_oe", dq_oe, 1'b0);
    aref_req = 1'b0;
    tick();
    tick();
    chk_eq("aref_wait_ack", aref_en, 1'b1);
    aref_ack = 1'b1;
    tick();
    aref_ack = 1'b0;
    chk_eq("aref_done_en", aref_en, 1'b0);
    expect_grant();
    wait_grant(gid);
    run_burst(gid, 5, 1'b0, 4'b0001);

    expect_grant();
    wait_grant(gid);
    run_burst(gid, 8, 1'b1, 4'b0000);
    chk_eq("post_burst_aref_en", aref_en, 1'b1);
    chk_eq("post_burst_aref_cmd", sdram_cmd, aref_cmd);
    aref_req = 1'b0;
    aref_ack = 1'b1;
    tick();
    aref_ack = 1'b0;
    chk_eq("post_burst_aref_clr", aref_en, 1'b0);

    bus.port_req = 4'b0100;
    expect_grant();
    wait_grant(gid);
    tick();
    tick();
    #3;
    RST_N = 1'b0;
    #1;
    chk_eq("async_rst_port_en", bus.port_en, '0);
    chk_eq("async_rst_dq_oe", dq_oe, 1'b0);
    chk_eq("async_rst_grant", bus.grant_id, '0);
    chk_eq("async_rst_cmd", sdram_cmd, init_cmd);
    exp_q.delete();
    tb_last      = NPORT - 1;
    bus.port_req = 4'b1111;
    @(negedge S_CLK);
    RST_N = 1'b1;
    tick();
    chk_eq("rst_release_init", sdram_cmd, init_cmd);
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    chk_eq("rst_release_idle", sdram_cmd, CMD_NOP);
    expect_grant();
    wait_grant(gid);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
